// File: rtl/step_pkg.sv
// ============================================================================
// Module   : step_pkg
// Purpose  : Shared types and constants for the step pulse generator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package step_pkg;

  localparam int DEF_CNT_W  = 16;
  localparam int DEF_PER_W  = 20;
  localparam int MIN_PERIOD = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/step_timer.sv
// ============================================================================
// Module   : step_timer
// Purpose  : Loadable down-counting period timer with zero (expire) flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module step_timer #(
  parameter int W = 22
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_tick,
  output logic         o_expired
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_tick) begin
      r_cnt <= r_cnt - {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/step_pulse_gen.sv
// ============================================================================
// Module   : step_pulse_gen
// Purpose  : Issues a counted, evenly spaced train of step strobes per command.
//            Optional macro STEP_PULSE_RAMP_EN adds a linear acceleration ramp.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module step_pulse_gen #(
  parameter int CNT_W = step_pkg::DEF_CNT_W,
  parameter int PER_W = step_pkg::DEF_PER_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic             cmd_dir,
  input  logic [PER_W-1:0] cmd_period,
  input  logic             abort,
  output logic             step,
  output logic             direction,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] steps_left
);

  import step_pkg::*;

  // Two extra bits so the ramp start value 4*P cannot overflow.
  localparam int               c_timer_w = PER_W + 2;
  localparam logic [PER_W-1:0] c_min_per = PER_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] c_one_cnt = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [c_timer_w-1:0] c_one_tmr = {{(c_timer_w-1){1'b0}}, 1'b1};

  state_t                 r_state, w_state_nxt;
  logic [CNT_W-1:0]       r_steps_left;
  logic                   r_dir;
  logic [PER_W-1:0]       r_per;
  logic [PER_W-1:0]       w_per_clamp;
  logic [c_timer_w-1:0]   w_start;
  logic [c_timer_w-1:0]   w_cur_nxt;
  logic                   w_accept;
  logic                   w_load;
  logic [c_timer_w-1:0]   w_load_val;
  logic                   w_tick;
  logic                   w_expired;

  assign w_per_clamp = (cmd_period < c_min_per) ? c_min_per : cmd_period;

`ifdef STEP_PULSE_RAMP_EN
  logic [c_timer_w-1:0] r_cur;
  logic [PER_W-1:0]     w_quarter;
  logic [c_timer_w-1:0] w_dec;
  logic [c_timer_w-1:0] w_cur_sub;

  assign w_start   = {w_per_clamp, 2'b00};
  assign w_quarter = r_per >> 2;
  assign w_dec     = (w_quarter == '0) ? c_one_tmr : {2'b00, w_quarter};
  assign w_cur_sub = r_cur - w_dec;
  assign w_cur_nxt = (w_cur_sub < {2'b00, r_per}) ? {2'b00, r_per} : w_cur_sub;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur <= '0;
    end else if (w_accept) begin
      r_cur <= w_start;
    end else if (step) begin
      r_cur <= w_cur_nxt;
    end
  end
`else
  assign w_start   = {2'b00, w_per_clamp};
  assign w_cur_nxt = {2'b00, r_per};
`endif

  assign w_accept = cmd_valid && (r_state == S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // step is combinational on abort so a coincident abort suppresses the strobe.
  always_comb begin
    w_state_nxt = r_state;
    cmd_ready   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    step        = 1'b0;
    w_tick      = 1'b0;
    w_load      = 1'b0;
    w_load_val  = w_start - c_one_tmr;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_load      = 1'b1;
          w_state_nxt = (cmd_steps == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        busy   = 1'b1;
        w_tick = 1'b1;
        if (abort) begin
          w_state_nxt = S_DONE;
        end else if (w_expired) begin
          step       = 1'b1;
          w_load     = 1'b1;
          w_load_val = w_cur_nxt - c_one_tmr;
          if (r_steps_left == c_one_cnt) w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dir        <= 1'b0;
      r_steps_left <= '0;
      r_per        <= c_min_per;
    end else if (w_accept) begin
      r_dir        <= cmd_dir;
      r_steps_left <= cmd_steps;
      r_per        <= w_per_clamp;
    end else if (step) begin
      r_steps_left <= r_steps_left - c_one_cnt;
    end
  end

  step_timer #(.W(c_timer_w)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_tick     (w_tick),
    .o_expired  (w_expired)
  );

  assign direction  = r_dir;
  assign steps_left = r_steps_left;

endmodule

`default_nettype wire

// File: tb/tb_step_pulse_gen.sv
// ============================================================================
// Module   : tb_step_pulse_gen
// Purpose  : Scoreboard bench for step_pulse_gen (directed move commands).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_step_pulse_gen;

  localparam int CNT_W = 16;
  localparam int PER_W = 20;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_steps = '0;
  logic             cmd_dir = 1'b0;
  logic [PER_W-1:0] cmd_period = '0;
  logic             abort = 1'b0;
  logic             step;
  logic             direction;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] steps_left;

  step_pulse_gen #(.CNT_W(CNT_W), .PER_W(PER_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_steps  (cmd_steps),
    .cmd_dir    (cmd_dir),
    .cmd_period (cmd_period),
    .abort      (abort),
    .step       (step),
    .direction  (direction),
    .busy       (busy),
    .done       (done),
    .steps_left (steps_left)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_done;
    int cyc;
    int sl;
    bit dir;
  } ev_t;

  ev_t q[$];
  int  n_pass  = 0;
  int  n_total = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference timing: offset from accept cycle of the n-th step.
  function automatic int step_off(input int p, input int n);
    int pc, cur, dec, t;
    pc = (p < 2) ? 2 : p;
`ifdef STEP_PULSE_RAMP_EN
    cur = 4 * pc;
    dec = ((pc >> 2) < 1) ? 1 : (pc >> 2);
`else
    cur = pc;
    dec = 0;
`endif
    t = 0;
    for (int i = 1; i <= n; i++) begin
      t += cur;
      cur = ((cur - dec) < pc) ? pc : (cur - dec);
    end
    return t;
  endfunction

  task automatic push_ev(input bit is_done, input int c, input int sl, input bit dir);
    ev_t e;
    e.is_done = is_done;
    e.cyc     = c;
    e.sl      = sl;
    e.dir     = dir;
    q.push_back(e);
  endtask

  task automatic push_move(input int acc, input int steps, input int p, input bit dir);
    for (int i = 1; i <= steps; i++) push_ev(1'b0, acc + step_off(p, i), steps - i + 1, dir);
    push_ev(1'b1, acc + step_off(p, steps) + 1, 0, dir);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int steps, input int p, input bit dir, input bit hold, output int acc);
    int budget;
    next_cycle();
    budget = 0;
    while (!cmd_ready && budget < 200) begin
      next_cycle();
      budget++;
    end
    if (!cmd_ready) chk("ready_timeout", 0, 1);
    cmd_valid  = 1'b1;
    cmd_steps  = CNT_W'(steps);
    cmd_period = PER_W'(p);
    cmd_dir    = dir;
    acc        = cyc;
    next_cycle();
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) next_cycle();
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((q.size() != 0 || !cmd_ready) && budget < 1000) begin
      next_cycle();
      budget++;
    end
    if (q.size() != 0 || !cmd_ready) chk("drain_timeout", q.size(), 0);
    repeat (3) next_cycle();
  endtask

  // Monitor: every strobe the DUT presents must match the head of the queue.
  always @(negedge clk) begin
    ev_t e;
    if (!rst && (step || done)) begin
      if (step && done) chk("step_and_done_together", 1, 0);
      if (q.size() == 0) begin
        chk("spurious_event_cycle", cyc, -1);
      end else begin
        e = q.pop_front();
        chk("event_kind_done", done, e.is_done);
        chk("event_cycle", cyc, e.cyc);
        chk("event_steps_left", steps_left, e.sl);
        chk("event_direction", direction, e.dir);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, a2, rc;

    repeat (3) next_cycle();
    rst = 1'b0;
    chk("rst_step", step, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_direction", direction, 0);
    chk("rst_steps_left", steps_left, 0);
    chk("rst_cmd_ready", cmd_ready, 1);

    // steps=3, period=5, dir=1: steps at +5,+10,+15, done at +16
    issue(3, 5, 1'b1, 1'b0, acc);
    push_move(acc, 3, 5, 1'b1);
    chk("run_busy", busy, 1);
    chk("run_ready_low", cmd_ready, 0);
    drain();
    chk("dir_held_idle", direction, 1);
    chk("sl_zero_after_move", steps_left, 0);

    // zero-length move: done one cycle after accept, never busy
    issue(0, 7, 1'b0, 1'b0, acc);
    push_ev(1'b1, acc + 1, 0, 1'b0);
    chk("zero_move_busy", busy, 0);
    drain();

    // period clamp to 2
    issue(3, 0, 1'b1, 1'b0, acc);
    push_move(acc, 3, 0, 1'b1);
    drain();
    issue(2, 1, 1'b0, 1'b0, acc);
    push_move(acc, 2, 1, 1'b0);
    drain();

    // abort coincident with second of four steps
    issue(4, 3, 1'b1, 1'b0, acc);
    push_ev(1'b0, acc + step_off(3, 1), 4, 1'b1);
    a2 = acc + step_off(3, 2);
    push_ev(1'b1, a2 + 1, 3, 1'b1);
    wait_until(a2);
    abort = 1'b1;
    next_cycle();
    abort = 1'b0;
    drain();
    chk("abort_steps_left", steps_left, 3);

    // abort while idle is ignored
    abort = 1'b1;
    next_cycle();
    abort = 1'b0;
    chk("idle_abort_ready", cmd_ready, 1);
    chk("idle_abort_busy", busy, 0);

    // reset mid-run with cmd_valid held throughout
    issue(10, 4, 1'b1, 1'b1, acc);
    push_ev(1'b0, acc + step_off(4, 1), 10, 1'b1);
    push_ev(1'b0, acc + step_off(4, 2), 9, 1'b1);
    rc = acc + step_off(4, 2) + 2;
    wait_until(rc - 1);
    chk("held_valid_ready", cmd_ready, 0);
    chk("held_valid_busy", busy, 1);
    chk("held_valid_steps_left", steps_left, 8);
    rst       = 1'b1;
    cmd_valid = 1'b0;
    next_cycle();
    rst = 1'b0;
    chk("midrun_rst_busy", busy, 0);
    chk("midrun_rst_direction", direction, 0);
    chk("midrun_rst_steps_left", steps_left, 0);
    chk("midrun_rst_ready", cmd_ready, 1);
    chk("midrun_rst_queue", q.size(), 0);
    repeat (20) next_cycle();

`ifdef STEP_PULSE_RAMP_EN
    // ramp: spacings 32, 30, 28, 26, 24
    issue(5, 8, 1'b0, 1'b0, acc);
    push_ev(1'b0, acc + 32, 5, 1'b0);
    push_ev(1'b0, acc + 62, 4, 1'b0);
    push_ev(1'b0, acc + 90, 3, 1'b0);
    push_ev(1'b0, acc + 116, 2, 1'b0);
    push_ev(1'b0, acc + 140, 1, 1'b0);
    push_ev(1'b1, acc + 141, 0, 1'b0);
    drain();
`else
    // constant spacing: steps at +6, +12, done at +13
    issue(2, 6, 1'b0, 1'b0, acc);
    push_ev(1'b0, acc + 6, 2, 1'b0);
    push_ev(1'b0, acc + 12, 1, 1'b0);
    push_ev(1'b1, acc + 13, 0, 1'b0);
    drain();
`endif

    chk("final_queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/step_pulse_gen.md
STEP_PULSE_GEN -- requirements
Module: step_pulse_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of step count.
REQ-002 SHALL have parameter PER_W, default 20, width of step period in clocks.
REQ-003 SHALL have clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have cmd_valid  input  1  move command offered.
REQ-006 SHALL have cmd_ready  output  1  block can accept a command.
REQ-007 SHALL have cmd_steps  input  CNT_W  number of steps to issue.
REQ-008 SHALL have cmd_dir  input  1  move direction (1 = reverse phase order in the downstream stage).
REQ-009 SHALL have cmd_period  input  PER_W  clocks between step pulses.
REQ-010 SHALL have abort  input  1  stop current move.
REQ-011 SHALL have step  output  1  one-cycle strobe that advances the downstream phase controller.
REQ-012 SHALL have direction  output  1  registered direction for the downstream phase controller.
REQ-013 SHALL have busy  output  1  move in progress.
REQ-014 SHALL have done  output  1  one-cycle pulse at end of move.
REQ-015 SHALL have steps_left  output  CNT_W  remaining steps.

Function
REQ-016 SHALL implement states IDLE, RUN, DONE.
REQ-017 SHALL drive cmd_ready high only in IDLE; accept occurs on cmd_valid && cmd_ready.
REQ-018 SHALL, on accept, latch cmd_dir into direction, cmd_steps into steps_left, and load the period counter with max(cmd_period,2)-1.
REQ-019 SHALL, on accept with cmd_steps==0, go to DONE without issuing any step.
REQ-020 SHALL, on accept with cmd_steps>0, go to RUN; busy high in RUN.
REQ-021 SHALL, in RUN, decrement the period counter each cycle; when it is 0, assert step for that cycle, decrement steps_left and reload the counter.
REQ-022 SHALL place the first step exactly max(cmd_period,2) cycles after the accept cycle; subsequent steps have the same spacing.
REQ-023 SHALL go RUN->DONE in the cycle the last step (steps_left 1->0) is issued.
REQ-024 SHALL, in DONE, assert done for exactly one cycle and return to IDLE.
REQ-025 SHALL, on abort in RUN, issue no further step and go to DONE next cycle; abort coincident with counter expiry suppresses that step; steps_left holds its value.
REQ-026 SHALL ignore abort in IDLE and DONE, and cmd_valid outside IDLE.
REQ-027 SHALL hold direction stable from accept until the next accept.

Reset
REQ-028 SHALL, with rst high at a clock edge, enter IDLE with step=0, done=0, busy=0, direction=0, steps_left=0, cmd_ready=1 next cycle.
REQ-029 SHALL, on reset mid-RUN, discard the move without a done pulse.

Configuration
REQ-030 SHALL honour macro STEP_PULSE_RAMP_EN.
REQ-031 SHALL, with STEP_PULSE_RAMP_EN defined, start each move at effective period 4*P (P = clamped cmd_period, internal width PER_W+2) and reduce it by max(P>>2,1) after each step, saturating at P.
REQ-032 SHALL, without STEP_PULSE_RAMP_EN, use constant period P for all steps.

Structure
REQ-033 SHALL place the state enum, default CNT_W/PER_W and the MIN_PERIOD=2 constant in shared package step_pkg.
REQ-034 SHALL place the loadable down-counting period timer (load, tick-enable, expire flag) in sub-module step_timer.

Verification
REQ-035 SHALL cover steps=3, period=5, dir=1: steps at accept+5, +10, +15; done at accept+16; direction=1 throughout.
REQ-036 SHALL cover steps=0: no step, done one cycle after accept, busy never high.
REQ-037 SHALL cover period=0 and 1: spacing clamped to 2 cycles.
REQ-038 SHALL cover abort in the cycle of the 2nd of 4 steps: only 1 step issued, steps_left=3, done next cycle.
REQ-039 SHALL cover rst asserted mid-RUN and cmd_valid held during RUN: no done, outputs at reset values, command during RUN not accepted.
REQ-040 SHALL cover, with STEP_PULSE_RAMP_EN, steps=5, period=8: step spacings 32, 30, 28, 26, 24.
